// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input conditioner: edge-mode encodings and
// helpers used by the per-channel debouncer and the event-flag logic.
package gpio_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // The counter has to hold values up to DEBOUNCE_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic logic mode_hit(input logic [1:0] mode, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (edge_mode_e'(mode))
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_debounce_channel.sv
// One GPIO channel: metastability synchroniser, consecutive-cycle debouncer and
// single-cycle rise/fall strobes that coincide with the level update edge.
module gpio_debounce_channel
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_sr;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;

    assign sync   = sync_sr[SYNC_STAGES-1];
    assign accept = (sync != level) && (cnt == CNT_LAST);
    // Strobes are combinational so the event flag sets on the same edge as level.
    assign rise   = accept && sync;
    assign fall   = accept && !sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_sr <= '0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], pin};
            if (sync == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input front end: per-channel debounced levels, sticky edge-event flags
// with masked CPU clear, and a single interrupt line.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   gpio_in,
    input  logic                  enable,
    input  logic [2*CHANNELS-1:0] edge_mode,
    input  logic                  clr_we,
    input  logic [CHANNELS-1:0]   clr_mask,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   event_flag,
    output logic                  irq
);

    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] set_bits;
    logic [CHANNELS-1:0] clr_bits;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        gpio_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .pin   (gpio_in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    always_comb begin
        set_bits = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            set_bits[i] = enable && mode_hit(edge_mode[2*i +: 2], rise[i], fall[i]);
        end
    end

    assign clr_bits = clr_we ? clr_mask : '0;

    // Set is OR-ed in after the clear so a coincident event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_flag <= '0;
        end else begin
            event_flag <= (event_flag & ~clr_bits) | set_bits;
        end
    end

    assign irq = |event_flag;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios plus randomized traffic
// compared every cycle against a window-based behavioural model.
module tb_gpio_input_conditioner;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   gpio_in = '0;
    logic            enable = 1'b1;
    logic [2*CH-1:0] edge_mode = '0;
    logic            clr_we = 1'b0;
    logic [CH-1:0]   clr_mask = '0;
    logic [CH-1:0]   level, event_flag;
    logic            irq;
    logic [CH-1:0]   level1, flag1;
    logic            irq1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .enable(enable),
        .edge_mode(edge_mode), .clr_we(clr_we), .clr_mask(clr_mask),
        .level(level), .event_flag(event_flag), .irq(irq)
    );

    gpio_input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .enable(enable),
        .edge_mode(edge_mode), .clr_we(clr_we), .clr_mask(clr_mask),
        .level(level1), .event_flag(flag1), .irq(irq1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: a channel's level flips once the synchronised value (the pin as
    // sampled SYNC edges earlier) has disagreed with it for DEB edges in a row.
    logic [CH-1:0] pin_q[$];
    logic [CH-1:0] win_q[$];
    logic [CH-1:0] m_level = '0, m_flag = '0, m_sync, m_next, m_set;
    bit            m_held;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            pin_q.delete();
            win_q.delete();
            repeat (SYNC) pin_q.push_back('0);
            repeat (DEB) win_q.push_back('0);
            m_level = '0;
            m_flag  = '0;
        end else begin
            m_sync = pin_q.pop_front();
            pin_q.push_back(gpio_in);
            void'(win_q.pop_front());
            win_q.push_back(m_sync);
            m_next = m_level;
            m_set  = '0;
            for (int c = 0; c < CH; c++) begin
                m_held = 1'b1;
                foreach (win_q[j]) if (win_q[j][c] == m_level[c]) m_held = 1'b0;
                if (m_held) begin
                    m_next[c] = ~m_level[c];
                    if (enable && ((m_next[c] && edge_mode[2*c]) || (!m_next[c] && edge_mode[2*c+1])))
                        m_set[c] = 1'b1;
                end
            end
            if (clr_we) m_flag = m_flag & ~clr_mask;
            m_flag  = m_flag | m_set;
            m_level = m_next;
        end
    end

    always @(negedge clk) begin
        check("level", 32'(level), 32'(m_level));
        check("event_flag", 32'(event_flag), 32'(m_flag));
        check("irq", 32'(irq), 32'(|m_flag));
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: fill every channel, then reset mid-cycle
        edge_mode = 8'b11_11_11_11;
        gpio_in = 4'b1111;
        repeat (15) @(negedge clk);
        check("t1_level_up", 32'(level), 32'hF);
        check("t1_flags_up", 32'(event_flag), 32'hF);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t1_rst_level", 32'(level), 32'h0);
        check("t1_rst_flag", 32'(event_flag), 32'h0);
        check("t1_rst_irq", 32'(irq), 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("t1_hold_level", 32'(level), 32'h0);
            check("t1_hold_irq", 32'(irq), 32'h0);
        end
        gpio_in = '0;
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // 2: rise on ch1, exact latency
        edge_mode = {2'b11, 2'b10, 2'b01, 2'b11};
        gpio_in[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) check("t2_deb1_early", 32'(level1[1]), 32'h0);
            if (k == 3) check("t2_deb1_lat", 32'(level1[1]), 32'h1);
            if (k == 9) check("t2_early", 32'(level[1]), 32'h0);
            if (k == 10) begin
                check("t2_level", 32'(level[1]), 32'h1);
                check("t2_model_level", 32'(m_level[1]), 32'h1);
                check("t2_flag", 32'(event_flag), 32'h2);
                check("t2_irq", 32'(irq), 32'h1);
            end
        end

        // 3: short glitch on ch0
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_level0", 32'(level[0]), 32'h0);
        check("t3_flag", 32'(event_flag), 32'h2);

        // 4: fall-only mode on ch2
        gpio_in[2] = 1'b1;
        repeat (12) @(negedge clk);
        check("t4_level_hi", 32'(level[2]), 32'h1);
        check("t4_no_rise_evt", 32'(event_flag), 32'h2);
        repeat (8) @(negedge clk);
        gpio_in[2] = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_level_lo", 32'(level[2]), 32'h0);
        check("t4_fall_evt", 32'(event_flag), 32'h6);
        check("t4_model_flag", 32'(m_flag), 32'h6);
        clr_we = 1'b1; clr_mask = 4'b0100;
        @(negedge clk);
        clr_we = 1'b0; clr_mask = '0;
        check("t4_cleared", 32'(event_flag), 32'h2);

        // 5: clear coincident with a ch0 event
        gpio_in[0] = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        clr_we = 1'b1; clr_mask = 4'b0011;
        @(posedge clk);
        #1;
        check("t5_level0", 32'(level[0]), 32'h1);
        check("t5_flag", 32'(event_flag), 32'h1);
        check("t5_irq", 32'(irq), 32'h1);
        @(negedge clk);
        clr_we = 1'b0; clr_mask = '0;

        // 6: enable low suppresses latching, then clear all
        enable = 1'b0;
        gpio_in[3] = 1'b1;
        repeat (12) @(negedge clk);
        check("t6_level3", 32'(level[3]), 32'h1);
        check("t6_flag", 32'(event_flag), 32'h1);
        enable = 1'b1;
        clr_we = 1'b1; clr_mask = 4'b1111;
        @(posedge clk);
        #1;
        check("t6_irq_clear", 32'(irq), 32'h0);
        check("t6_flag_clear", 32'(event_flag), 32'h0);
        @(negedge clk);
        clr_we = 1'b0; clr_mask = '0;

        // randomized traffic, with one mid-debounce reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(9) == 0) gpio_in[c] = ~gpio_in[c];
            enable = ($urandom_range(15) != 0);
            if ($urandom_range(63) == 0) edge_mode = 8'($urandom);
            clr_we = ($urandom_range(7) == 0);
            clr_mask = 4'($urandom);
            if (i == 1500) begin
                @(posedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
Parametrised front end for the board's GPIO button/switch inputs, feeding the CPU's memory-mapped I/O space.
- Per channel: metastability synchroniser, counter-based debouncer, configurable edge detector.
- Edge events latch into sticky flags; the CPU clears them with a masked write strobe.
- Replaces direct use of raw gpio1 bits in top with clean levels, latched events and a single interrupt line.

Parameters:
CHANNELS, 4, number of independent GPIO input channels (1..32)
SYNC_STAGES, 2, synchroniser flip-flop depth (>=2)
DEBOUNCE_CYCLES, 1000, consecutive cycles a new synchronised value must hold before acceptance (>=1)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
gpio_in  input  CHANNELS  raw asynchronous pin levels
enable  input  1  1 = events may be latched; 0 = event latching suppressed (debounce still runs)
edge_mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr_we  input  1  single-cycle clear strobe
clr_mask  input  CHANNELS  event bits to clear when clr_we=1
level  output  CHANNELS  debounced stable level per channel
event_flag  output  CHANNELS  sticky latched edge events
irq  output  1  OR of event_flag

Behaviour:
- Reset (async assert, release synchronous to clk): synchroniser FFs, level, debounce counters, event_flag all 0; irq 0.
- Synchroniser: SYNC_STAGES-deep shift per channel; sync[i] is the last stage.
- Debounce, per channel, each rising edge:
  - sync == level: counter <= 0.
  - sync != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != level and counter == DEBOUNCE_CYCLES-1: level <= sync; counter <= 0.
- Any mismatch shorter than DEBOUNCE_CYCLES cycles resets the counter and never reaches level.
- Latency: a clean input step, held, appears on level exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- DEBOUNCE_CYCLES=1: level follows sync with one cycle delay.
- Edge detect: a qualifying transition is the level update itself; rise = 0->1, fall = 1->0, filtered by edge_mode.
- event_flag[i] sets on the same clock edge that level[i] changes, if enable=1 and the mode matches.
- Clear: on an edge with clr_we=1, event_flag[i] <= 0 for every i with clr_mask[i]=1.
- Simultaneous set and clear on one channel: set wins; the flag stays 1 and the event is not lost.
- clr_we=0: clr_mask ignored.
- edge_mode or enable changes: take effect on the next edge; existing flags are untouched.
- irq: combinational OR of registered event_flag; glitch-free; stays 1 until all flags are cleared.
- Reset mid-debounce: counters and level return to 0 immediately; a held input re-qualifies with full latency after release.
- No counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package gpio_pkg holds:
  - mode encodings: EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11
  - a function computing CNT_W
- One sub-module, gpio_debounce_channel:
  - contains synchroniser, counter and level for one channel
  - outputs level plus rise/fall strobes
  - instantiated CHANNELS times by a generate loop
- The top-level block holds the event_flag register, the clear logic and the irq OR.

Test Plan (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, enable=1):
1. Assert rst mid-cycle with inputs 4'b1111 -> level, event_flag, irq are 0 immediately and stay 0 while rst=1.
2. Mode 01 on ch1; gpio_in[1] 0->1 held -> level[1] rises exactly 10 edges later; event_flag=4'b0010 on that same edge; irq=1.
3. ch0 glitch high for 5 cycles, then low -> level[0] and event_flag[0] never change.
4. Mode 10 on ch2; pulse gpio_in[2] high for 20 cycles -> no event on the rise; event_flag[2]=1 on the falling level update.
5. With event_flag=4'b0010, pulse clr_we with clr_mask=4'b0011 on the same edge ch0 (mode 11) latches an edge -> event_flag=4'b0001 (ch0 set wins, ch1 cleared); irq stays 1.
6. enable=0 with a clean edge on ch3 (mode 11) -> level[3] updates, event_flag[3]=0. Re-enable, then clear all flags -> irq=0 the same cycle after the clearing edge.
